// File: rtl/smart_car_pkg.sv
// Shared smart-car constants and the UART transmit arbiter state type.
// The default byte time is derived from the system clock and UART baud rate.
package smart_car_pkg;

    localparam int CLK_HZ              = 50_000_000;
    localparam int UART_BAUD           = 9600;
    localparam int UART_BITS_PER_BYTE  = 10;
    localparam int TXARB_CLKS_PER_BYTE = (CLK_HZ / UART_BAUD) * UART_BITS_PER_BYTE;
    localparam int TXARB_FRAME_TIMEOUT = 500_000;

    typedef enum logic [1:0] {
        ARB,
        SEND,
        WAIT,
        CHK
    } txarb_state_t;

endpackage

// File: rtl/txarb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping around, returned both as a one-hot grant and as an index.
module txarb_rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int unsigned j;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-granular arbiter sharing one uart_tx among NREQ requesters,
// pacing bytes at the UART byte time. Define TXARB_CHKSUM_EN to append an XOR checksum byte.
module uart_tx_arbiter
    import smart_car_pkg::*;
#(
    parameter int NREQ          = 3,
    parameter int CLKS_PER_BYTE = TXARB_CLKS_PER_BYTE,
    parameter int FRAME_TIMEOUT = TXARB_FRAME_TIMEOUT
) (
    input  logic              clk0,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ack,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_en,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);

    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = $clog2(CLKS_PER_BYTE);
    localparam int TO_W  = $clog2(FRAME_TIMEOUT);

    txarb_state_t      state;
    logic [IW-1:0]     g;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     next_ptr;
    logic              last_flag;
    logic [CNT_W-1:0]  cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
`ifdef TXARB_CHKSUM_EN
    logic [7:0]        chk;
    logic              chk_sent;
`endif

    txarb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .idx       (pick_idx)
    );

    always_comb begin
        next_ptr = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state        <= ARB;
            grant        <= '0;
            g            <= '0;
            rr_ptr       <= '0;
            req_ack      <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            busy         <= 1'b0;
            last_flag    <= 1'b0;
            cnt          <= '0;
            to_cnt       <= '0;
`ifdef TXARB_CHKSUM_EN
            chk          <= '0;
            chk_sent     <= 1'b0;
`endif
        end else begin
            req_ack    <= '0;
            uart_tx_en <= 1'b0;
            case (state)
                ARB: begin
                    if (|req_valid) begin
                        state  <= SEND;
                        busy   <= 1'b1;
                        grant  <= pick_grant;
                        g      <= pick_idx;
                        to_cnt <= '0;
`ifdef TXARB_CHKSUM_EN
                        chk      <= '0;
                        chk_sent <= 1'b0;
`endif
                    end
                end
                SEND: begin
                    if (req_valid[g]) begin
                        uart_tx_data <= req_data[8*g +: 8];
                        uart_tx_en   <= 1'b1;
                        req_ack      <= grant;
                        last_flag    <= req_last[g];
                        to_cnt       <= '0;
                        cnt          <= CNT_W'(CLKS_PER_BYTE - 1);
                        state        <= WAIT;
`ifdef TXARB_CHKSUM_EN
                        chk          <= chk ^ req_data[8*g +: 8];
`endif
                    end else if (to_cnt == TO_W'(FRAME_TIMEOUT - 1)) begin
                        // Stalled owner: drop the frame unfinished, no checksum.
                        to_cnt <= '0;
                        rr_ptr <= next_ptr;
                        grant  <= '0;
                        busy   <= 1'b0;
                        state  <= ARB;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
`ifdef TXARB_CHKSUM_EN
                    end else if (chk_sent) begin
                        chk_sent <= 1'b0;
                        rr_ptr   <= next_ptr;
                        grant    <= '0;
                        busy     <= 1'b0;
                        state    <= ARB;
                    end else if (last_flag) begin
                        state <= CHK;
`else
                    end else if (last_flag) begin
                        rr_ptr <= next_ptr;
                        grant  <= '0;
                        busy   <= 1'b0;
                        state  <= ARB;
`endif
                    end else begin
                        state <= SEND;
                    end
                end
`ifdef TXARB_CHKSUM_EN
                CHK: begin
                    uart_tx_data <= chk;
                    uart_tx_en   <= 1'b1;
                    cnt          <= CNT_W'(CLKS_PER_BYTE - 1);
                    last_flag    <= 1'b0;
                    chk_sent     <= 1'b1;
                    state        <= WAIT;
                end
`endif
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the car's single outbound UART (`uart_tx` → `tx`) among several byte-stream requesters, such as the distance report, heading report and status/echo path. It grants the line one whole frame at a time in round-robin order. It paces bytes at the UART byte time, since `uart_tx` has no busy flag, and releases a stalled requester after a timeout. It sits between the control logic (`action` and sensor front-ends) and `uart_tx`, replacing the direct `uart_tx_data`/`uart_tx_en` drive.

## Interface
- `NREQ`, 3, number of requesters (2..8)
- `CLKS_PER_BYTE`, 52080, cycles reserved per transmitted byte (10 bits at 9600 baud, 50 MHz); minimum 4
- `FRAME_TIMEOUT`, 500000, cycles a granted requester may leave `req_valid` low mid-frame before losing the grant
- `clk0` in 1: 50 MHz clock
- `rst` in 1: reset, asynchronous, active-high
- `req_valid` in NREQ: requester i presents a byte
- `req_data` in 8*NREQ: byte of requester i at bits [8i+7:8i]
- `req_last` in NREQ: presented byte ends the frame
- `req_ack` out NREQ: one-cycle pulse, byte of requester i accepted
- `uart_tx_data` out 8: byte to `uart_tx`
- `uart_tx_en` out 1: one-cycle send strobe to `uart_tx`
- `grant` out NREQ: one-hot current owner, 0 when idle
- `busy` out 1: high in any state except ARB

## Operation
- Requester handshake:
  - Hold `req_valid`, `req_data` and `req_last` stable until `req_ack` pulses.
  - The next byte may be presented in the cycle after the ack.
- States:
  - ARB: if any `req_valid` is high, pick the first valid index at or after `rr_ptr` (wrapping), set `grant`, clear `chk` and go to SEND. Otherwise stay.
  - SEND: if `req_valid[g]` is high:
    - Register `uart_tx_data=req_data[g]`, `uart_tx_en=1` and `req_ack[g]=1` for exactly one cycle.
    - Update `chk ^= data` and record `last_flag=req_last[g]`.
    - Load `cnt=CLKS_PER_BYTE-1` and go to WAIT.
  - SEND, with `req_valid[g]` low: increment `to_cnt`. When `to_cnt` reaches `FRAME_TIMEOUT-1`, abandon the frame (no checksum), set `rr_ptr=g+1 mod NREQ`, clear `grant` and go to ARB. `to_cnt` clears on every accepted byte.
  - WAIT: decrement `cnt`. At 0:
    - `last_flag=0`: go to SEND.
    - `last_flag=1`: go to CHK if checksum is enabled. Otherwise set `rr_ptr=g+1 mod NREQ`, clear `grant` and go to ARB.
  - CHK (checksum enabled only): one cycle with `uart_tx_data=chk`, `uart_tx_en=1` and no `req_ack`. Load `cnt` and go to WAIT with `last_flag` cleared and `chk_sent=1`. At the end of that WAIT, advance `rr_ptr`, clear `grant` and go to ARB.
- Ownership and priority:
  - The grant never changes inside a frame.
  - Other requesters' `req_valid` is ignored until ARB.
  - After reset, `rr_ptr=0`, so requester 0 wins simultaneous requests.
- Counter widths: `cnt` is `$clog2(CLKS_PER_BYTE)` bits and `to_cnt` is `$clog2(FRAME_TIMEOUT)` bits. Neither counter wraps.

## Timing
- Reset values:
  - State ARB.
  - `grant=0`, `req_ack=0`, `uart_tx_en=0`, `uart_tx_data=8'h00`, `busy=0`.
  - `rr_ptr=0`, `chk=0`, all counters 0.
- Reset asserted mid-frame aborts immediately: no further strobe, and the frame is not resumed.
- First-byte latency: request seen in ARB at cycle t → SEND at t+1 → `uart_tx_en` and `req_ack` high at t+2, given `req_valid` is still high.
- Byte spacing: consecutive strobes in a frame are exactly `CLKS_PER_BYTE+1` cycles apart if the next byte is ready at SEND.
- All outputs are registered. `uart_tx_en` and `req_ack` are never high for two consecutive cycles.
- A single-byte frame (`req_last` on its first byte) is legal.
- Dropping `req_valid` before the ack is tolerated: the requester simply waits in SEND and the timeout applies.

## Configuration
- `TXARB_CHKSUM_EN` defined: after the last byte of every completed frame, one XOR checksum byte (XOR of all frame data bytes) is sent via CHK.
- `TXARB_CHKSUM_EN` not defined: CHK state, `chk` register and `chk_sent` are absent. The frame ends after the byte flagged `req_last`.
- A timed-out frame never gets a checksum.

## Structure
- Shared package `smart_car_pkg` holds:
  - The state enum `txarb_state_t` (ARB, SEND, WAIT, CHK).
  - The constants `CLK_HZ=50_000_000` and `UART_BAUD=9600`, from which the default `CLKS_PER_BYTE` is derived.
- One sub-module, `txarb_rr_pick`: combinational round-robin picker (inputs `req_valid`, `rr_ptr`; outputs one-hot grant and index).
- All sequencing logic stays in `uart_tx_arbiter`.

## Test plan
All scenarios use `CLKS_PER_BYTE=8` and `FRAME_TIMEOUT=20`.
- Single request: requester 1 sends frame 8'h41, 8'h42 (`last`) → strobes carry 41 then 42, 9 cycles apart. `req_ack[1]` pulses twice. Return to ARB with `grant=0`. With checksum enabled, a third strobe carries 8'h03.
- Simultaneous requests: requesters 0 and 2 each send a 2-byte frame after reset → all of requester 0's bytes go out before any of requester 2's, with no interleaving.
- Round-robin: requesters 0, 1 and 2 continuously re-request 1-byte frames → grant order 0, 1, 2, 0, 1, 2.
- Timeout: requester 0 sends 8'h10 without `last`, then drops `req_valid` → 20 cycles after entering SEND, `grant` clears. No checksum is sent. Requester 1 is served next.
- Reset mid-frame: assert `rst` during WAIT of byte 2 of 3 → all outputs are at reset values in the same cycle. After release, the frame restarts from ARB only on a new request.
- Ack discipline: `req_valid` is held high continuously → `uart_tx_en` and `req_ack` are never high on consecutive cycles, and `req_ack` is never high outside the granted index.
